mul_wb_seq: RTL and testbench
=============================

MUL_WB_SEQ -- requirements
Module: mul_wb_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the register-file address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the following multiplier-result ports:
- in_valid, input, 1 bit: a multiplier result is presented.
- in_ready, output, 1 bit: the result is accepted this cycle.
- cmd, input, 3 bits: multiply opcode; bit 2 = long, bit 1 = signed, bit 0 = accumulate.
- ret1, input, DATA_W: result word for Rd (RdHi if long).
- ret2, input, DATA_W: result word for Ra (RdLo if long).
- addr1, input, ADDR_W: register for ret1.
- addr2, input, ADDR_W: register for ret2.
- set_flags, input, 1 bit: S bit of the instruction.
- flush, input, 1 bit: abort all pending writes.
REQ-006 The block SHALL have the following register-file and pipeline ports:
- rf_we, output, 1 bit: register write enable.
- rf_wa, output, ADDR_W: register write address.
- rf_wd, output, DATA_W: register write data.
- stall, output, 1 bit: hold upstream stages.
- flag_we, output, 1 bit: write N and Z.
- flag_nz, output, 2 bits: {N, Z}.

Function
REQ-007 The block SHALL implement the FSM states IDLE, WR1 and WR2.
REQ-008 in_ready SHALL be 1 in IDLE, 1 in the final write cycle of the current op, and 0 otherwise.
REQ-009 An op SHALL be accepted when in_valid and in_ready are both 1; on acceptance ret1, ret2, addr1, addr2, cmd and set_flags SHALL be registered.
REQ-010 The cycle after acceptance the FSM SHALL be in WR1, driving rf_we=1, rf_wa=addr1 and rf_wd=ret1 from the registered copies.
REQ-011 For short ops (cmd[2]=0), WR1 SHALL be the final write cycle; the next state SHALL be WR1 if a new op is accepted that cycle, else IDLE.
REQ-012 For long ops (cmd[2]=1), WR1 SHALL go to WR2, which drives rf_we=1, rf_wa=addr2 and rf_wd=ret2; WR2 SHALL be the final write cycle.
REQ-013 Write latency SHALL be 1 cycle from acceptance to the first write, and short ops SHALL sustain 1 op per cycle.
REQ-014 Long ops SHALL sustain 1 op per 2 cycles.
REQ-015 stall SHALL equal in_valid AND NOT in_ready.
REQ-016 If addr1 equals addr2 on a long op, both writes SHALL occur in order, so ret2 is the final value.
REQ-017 When flush=1, the next state SHALL be IDLE regardless of state.
REQ-018 When flush=1, rf_we and flag_we SHALL be 0 in the same cycle.
REQ-019 When flush=1, no op SHALL be accepted that cycle (in_ready forced to 0).
REQ-020 Outside WR1 and WR2, rf_we SHALL be 0, and rf_wa and rf_wd SHALL be 0.

Reset
REQ-021 With reset=1 at a clock edge, state SHALL become IDLE and all registered op fields SHALL be cleared.
REQ-022 During reset, outputs SHALL be rf_we=0, rf_wa=0, rf_wd=0, flag_we=0, flag_nz=0 and in_ready=0.
REQ-023 reset SHALL take priority over flush and in_valid; a write in progress SHALL be dropped with no partial second write afterward.

Configuration
REQ-024 Macro MUL_WB_FLAGS_EN SHALL control flag generation.
REQ-025 When MUL_WB_FLAGS_EN is defined, flag_we=1 SHALL be asserted in the final write cycle of an op whose set_flags=1.
REQ-026 When MUL_WB_FLAGS_EN is defined, N SHALL be the MSB of ret1.
REQ-027 When MUL_WB_FLAGS_EN is defined, Z SHALL be (ret1==0) for short ops and ({ret1,ret2}==0) for long ops.
REQ-028 When MUL_WB_FLAGS_EN is not defined, flag_we and flag_nz SHALL be constant 0, set_flags SHALL be ignored, and no flag logic SHALL be synthesized.

Structure
REQ-029 Shared package mul_pkg SHALL hold the cmd encodings (MUL=000, MLA=001, UMULL=100, UMLAL=101, SMULL=110, SMLAL=111), the FSM state enum, and a helper returning "is long" from cmd.
REQ-030 The block SHALL be a single module with no sub-modules; the multiplier stays a separate upstream instance.

Verification
REQ-031 Short op: MUL, ret1=0x0000_0006, addr1=3, accepted at cycle t -> rf_we=1, rf_wa=3, rf_wd=6 at t+1; IDLE at t+2.
REQ-032 Long op: UMULL, ret1=0x1, ret2=0xFFFF_FFFE, addr1=5, addr2=4 -> cycle t+1 writes r5=0x1, t+2 writes r4=0xFFFF_FFFE; stall=1 at t+1 if in_valid is held.
REQ-033 Back-to-back: three consecutive MUL ops held valid -> writes on three consecutive cycles; stall stays 0.
REQ-034 Flush mid-op: flush=1 in WR1 of SMLAL -> no WR2 write, IDLE next cycle, in_ready=0 during flush.
REQ-035 Reset mid-op: reset=1 in WR1 of a long op -> rf_we=0 in all following cycles until a new accept.
REQ-036 Flags (MUL_WB_FLAGS_EN defined): UMULL with set_flags=1, ret1=0, ret2=0 -> flag_we=1, flag_nz=01 in WR2; with ret1=0x8000_0000 -> flag_nz=10.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply write-back sequencer: cmd encodings,
// FSM state type and a long-op decode helper.
package mul_pkg;

    localparam logic [2:0] CMD_MUL   = 3'b000;
    localparam logic [2:0] CMD_MLA   = 3'b001;
    localparam logic [2:0] CMD_UMULL = 3'b100;
    localparam logic [2:0] CMD_UMLAL = 3'b101;
    localparam logic [2:0] CMD_SMULL = 3'b110;
    localparam logic [2:0] CMD_SMLAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } state_e;

    function automatic logic is_long(input logic [2:0] c);
        return c[2];
    endfunction

endpackage

// File: rtl/mul_wb_seq.sv
// Sequences multiplier results into register-file writes (one for short ops,
// two for long ops). Define MUL_WB_FLAGS_EN to generate N/Z flag updates.
module mul_wb_seq
    import mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cmd,
    input  logic [DATA_W-1:0] ret1,
    input  logic [DATA_W-1:0] ret2,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              set_flags,
    input  logic              flush,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              stall,
    output logic              flag_we,
    output logic [1:0]        flag_nz
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ret1_q, ret1_d, ret2_q, ret2_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              accept;
    logic              final_wr;

    always_comb begin
        state_d  = state_q;
        ret1_d   = ret1_q;
        ret2_d   = ret2_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        cmd_d    = cmd_q;
        in_ready = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_wd    = '0;
        final_wr = 1'b0;

        case (state_q)
            IDLE: in_ready = 1'b1;
            WR1: begin
                rf_we = 1'b1;
                rf_wa = addr1_q;
                rf_wd = ret1_q;
                if (!is_long(cmd_q)) begin
                    in_ready = 1'b1;
                    final_wr = 1'b1;
                end
            end
            WR2: begin
                rf_we    = 1'b1;
                rf_wa    = addr2_q;
                rf_wd    = ret2_q;
                in_ready = 1'b1;
                final_wr = 1'b1;
            end
            default: ;
        endcase

        // Flush and reset both squash the current write and block acceptance.
        if (flush || reset) begin
            in_ready = 1'b0;
            rf_we    = 1'b0;
            rf_wa    = '0;
            rf_wd    = '0;
            final_wr = 1'b0;
        end

        accept = in_valid && in_ready;

        case (state_q)
            IDLE:    state_d = accept ? WR1 : IDLE;
            WR1:     state_d = is_long(cmd_q) ? WR2 : (accept ? WR1 : IDLE);
            WR2:     state_d = accept ? WR1 : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;

        if (accept) begin
            ret1_d  = ret1;
            ret2_d  = ret2;
            addr1_d = addr1;
            addr2_d = addr2;
            cmd_d   = cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ret1_q  <= '0;
            ret2_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            ret1_q  <= ret1_d;
            ret2_q  <= ret2_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            cmd_q   <= cmd_d;
        end
    end

    assign stall = in_valid && !in_ready;

    // Sign/accumulate bits matter only to the upstream multiplier.
    logic [1:0] unused_cmd;
    assign unused_cmd = cmd_q[1:0];

`ifdef MUL_WB_FLAGS_EN
    logic sf_q, sf_d;
    logic z_flag;

    always_comb begin
        sf_d = sf_q;
        if (accept) sf_d = set_flags;
    end

    always_ff @(posedge clk) begin
        if (reset) sf_q <= 1'b0;
        else       sf_q <= sf_d;
    end

    assign z_flag  = is_long(cmd_q) ? ((ret1_q == '0) && (ret2_q == '0)) : (ret1_q == '0);
    assign flag_we = final_wr && sf_q;
    assign flag_nz = flag_we ? {ret1_q[DATA_W-1], z_flag} : 2'b00;
`else
    logic unused_flags;
    assign unused_flags = set_flags ^ final_wr;
    assign flag_we = 1'b0;
    assign flag_nz = 2'b00;
`endif

endmodule

// File: tb/tb_mul_wb_seq.sv
// Scoreboard bench for mul_wb_seq: an occupancy model predicts acceptance and
// queues timestamped writes; a monitor matches them against the write port.
module tb_mul_wb_seq;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, set_flags, flush;
    logic [2:0]    cmd;
    logic [DW-1:0] ret1, ret2, rf_wd;
    logic [AW-1:0] addr1, addr2, rf_wa;
    logic          rf_we, stall, flag_we;
    logic [1:0]    flag_nz;

    mul_wb_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .ret1(ret1), .ret2(ret2), .addr1(addr1), .addr2(addr2),
        .set_flags(set_flags), .flush(flush), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .stall(stall), .flag_we(flag_we), .flag_nz(flag_nz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          fwe;
        logic [1:0]    nz;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  pending = 0;

`ifdef MUL_WB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Occupancy model: pending = writes still owed by the op in flight.
    always @(negedge clk) begin
        bit  rdy, acc, lng;
        wr_t e;
        if (reset) begin
            q.delete();
            pending = 0;
            chk("in_ready_reset", {63'd0, in_ready}, 64'd0);
        end else if (flush) begin
            q.delete();
            pending = 0;
            chk("in_ready_flush", {63'd0, in_ready}, 64'd0);
            chk("stall_flush", {63'd0, stall}, {63'd0, in_valid});
        end else begin
            rdy = (pending <= 1);
            acc = in_valid && rdy;
            lng = cmd[2];
            chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
            chk("stall", {63'd0, stall}, {63'd0, in_valid && !rdy});
            if (acc) begin
                e.cyc = cyc + 1;
                e.wa  = addr1;
                e.wd  = ret1;
                e.fwe = FLAGS && set_flags && !lng;
                e.nz  = {ret1[DW-1], lng ? (ret1 == 0 && ret2 == 0) : (ret1 == 0)};
                q.push_back(e);
                if (lng) begin
                    e.cyc = cyc + 2;
                    e.wa  = addr2;
                    e.wd  = ret2;
                    e.fwe = FLAGS && set_flags;
                    q.push_back(e);
                end
            end
            pending = (pending > 0 ? pending - 1 : 0) + (acc ? (lng ? 2 : 1) : 0);
        end
    end

    // Monitor: runs just after the model so flush/reset drops are already applied.
    always @(negedge clk) begin
        wr_t e;
        bit  exp_we;
        #1;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("stale_write", 64'd1, 64'd0);
        end
        exp_we = (q.size() > 0 && q[0].cyc == cyc);
        chk("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
        if (exp_we) begin
            e = q.pop_front();
            if (rf_we) begin
                chk("rf_wa", {60'd0, rf_wa}, {60'd0, e.wa});
                chk("rf_wd", {32'd0, rf_wd}, {32'd0, e.wd});
            end
            chk("flag_we", {63'd0, flag_we}, {63'd0, e.fwe});
            if (e.fwe) chk("flag_nz", {62'd0, flag_nz}, {62'd0, e.nz});
        end else begin
            chk("rf_wa_idle", {60'd0, rf_wa}, 64'd0);
            chk("rf_wd_idle", {32'd0, rf_wd}, 64'd0);
            chk("flag_we_idle", {63'd0, flag_we}, 64'd0);
        end
        if (!FLAGS || reset) chk("flag_nz_zero", {62'd0, flag_nz}, 64'd0);
    end

    task automatic drive(input bit v, input logic [2:0] c, input logic [DW-1:0] r1,
                         input logic [DW-1:0] r2, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input bit sf, input bit fl, input bit rs);
        in_valid = v; cmd = c; ret1 = r1; ret2 = r2; addr1 = a1; addr2 = a2;
        set_flags = sf; flush = fl; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [2:0] cmds [6];
        logic [DW-1:0] r1, r2;
        cmds = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        in_valid = 0; cmd = 0; ret1 = 0; ret2 = 0; addr1 = 0; addr2 = 0;
        set_flags = 0; flush = 0; reset = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) drive(1, 3'b100, 32'h5, 32'h6, 1, 2, 1, 1, 1);
        idle(2);
        // Short op, then long op held valid across its stall.
        drive(1, 3'b000, 32'h6, 32'h0, 3, 0, 0, 0, 0);
        idle(2);
        drive(1, 3'b100, 32'h1, 32'hFFFF_FFFE, 5, 4, 0, 0, 0);
        drive(1, 3'b100, 32'h1, 32'hFFFF_FFFE, 5, 4, 0, 0, 0);
        idle(3);
        // Three back-to-back short ops.
        drive(1, 3'b000, 32'h11, 0, 1, 0, 0, 0, 0);
        drive(1, 3'b001, 32'h22, 0, 2, 0, 0, 0, 0);
        drive(1, 3'b000, 32'h33, 0, 3, 0, 0, 0, 0);
        idle(2);
        // Flush in WR1 of SMLAL, with a new op offered during the flush.
        drive(1, 3'b111, 32'hAAAA, 32'hBBBB, 7, 8, 1, 0, 0);
        drive(1, 3'b000, 32'hCCCC, 0, 9, 0, 1, 1, 0);
        idle(3);
        // Reset in WR1 of a long op.
        drive(1, 3'b110, 32'h1234, 32'h5678, 10, 11, 1, 0, 0);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // Same-address long op and flag cases.
        drive(1, 3'b101, 32'h7, 32'h9, 6, 6, 0, 0, 0);
        idle(2);
        drive(1, 3'b100, 32'h0, 32'h0, 2, 3, 1, 0, 0);
        idle(2);
        drive(1, 3'b100, 32'h8000_0000, 32'h0, 2, 3, 1, 0, 0);
        idle(2);
        drive(1, 3'b000, 32'h0, 32'h5, 4, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: r1 = 0;
                1: r1 = 32'h8000_0000 | $urandom;
                default: r1 = $urandom;
            endcase
            r2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            drive($urandom_range(0, 9) < 7, cmds[$urandom_range(0, 5)], r1, r2,
                  AW'($urandom), AW'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end
        idle(5);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
